banked_ram: RTL and testbench
=============================

# banked_ram

Parametrised successor to the fixed 64×16 register RAM. Storage is 2^ADDR_W words of WIDTH bits, split into 2^BANK_W equal banks. The block adds three things the fixed RAM lacks: a registered read port with a valid flag, a selectable read-during-write mode, and a runtime clear sequencer that scrubs the array one word per cycle. It is the data-memory building block for the CPU datapath and replaces hand-instantiated fixed-size RAM stacks.

## Interface
Parameters:
- WIDTH, default 16: data word width in bits.
- ADDR_W, default 6: address width. DEPTH = 2^ADDR_W words.
- BANK_W, default 3: bank-select width. Requires 1 ≤ BANK_W < ADDR_W. There are 2^BANK_W banks of 2^(ADDR_W−BANK_W) words each.
- READ_MODE, default 0: read-during-write behaviour. 0 = read-first (return the old word). 1 = write-first (return the new word).

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in, input, WIDTH: write data.
- load, input, 1: write enable.
- address, input, ADDR_W: shared read/write address. Bank = address[ADDR_W-1 -: BANK_W]; word within bank = the low ADDR_W−BANK_W bits.
- rd_en, input, 1: read request.
- clear, input, 1: start-scrub request, level sampled.
- out, output, WIDTH: registered read data.
- out_valid, output, 1: out holds data from a read accepted on the previous edge.
- busy, output, 1: clear sequence in progress.

## Operation
- Reset (rst_n=0, asynchronous):
  - Every storage word = 0.
  - out = 0, out_valid = 0, busy = 0.
  - State = IDLE, clear counter = 0.
- Write decode: load is routed to exactly one bank through a one-hot bank select. A write changes only mem[address].
- State machine, two states:
  - IDLE → CLEAR at an edge with clear=1. Counter set to 0, busy←1.
  - CLEAR: each edge writes 0 to mem[counter] and increments the counter.
  - CLEAR → IDLE at the edge that writes word DEPTH−1. busy←0, counter←0.
- IDLE, clear=0:
  - Write: load=1 → mem[address]←in.
  - Read: rd_en=1 → out←mem[address], out_valid←1.
  - No read: rd_en=0 → out holds its value, out_valid←0.
- Same-edge read and write to the same address:
  - READ_MODE=0: out gets the pre-write word.
  - READ_MODE=1: out gets in.
  - Different addresses: both operations complete independently.
- Clear priority: in the IDLE edge that samples clear=1, any load is dropped and any rd_en is ignored (out_valid←0, out holds).
- While in CLEAR:
  - load, rd_en and clear are all ignored.
  - out holds its value and out_valid stays 0.
  - A clear held high through the end of a sweep starts a new sweep on the first IDLE edge after it.
- Reset during CLEAR: abort immediately to the reset state above. The array is fully zeroed by reset regardless of sweep progress.
- Counter width is ADDR_W. It never wraps past DEPTH−1 because the FSM exits at that value.

## Timing
- Write latency: 1 edge. Data written at edge N is readable by an rd_en sampled at edge N+1.
- Read latency: 1 cycle. rd_en sampled at edge N → out and out_valid update at edge N. They are valid from N until N+1.
- Back-to-back reads: one per cycle; out_valid stays high continuously.
- Clear timing, for clear sampled at edge N:
  - busy is high from edge N to edge N+DEPTH, i.e. DEPTH cycles.
  - Word k is zeroed at edge N+1+k.
  - The first accepted operation is at edge N+DEPTH+1.
- Outputs are register-driven only; there is no combinational path from any input to any output.

## Test plan
- Reset, then read addresses 0, 21, 63 (defaults) → out=0x0000 with out_valid=1 one cycle after each rd_en; busy=0.
- Write 0xA5A5 to 9 and 0x1234 to 57, then read 9, 57, 10 back-to-back → 0xA5A5, 0x1234, 0x0000 on consecutive cycles. Check bank decode: only bank 1 and bank 7 words change.
- Same-edge load=1, rd_en=1 at address 5, old value 0x1111, in=0x2222:
  - READ_MODE=0 → out=0x1111.
  - READ_MODE=1 → out=0x2222.
  - Subsequent read of 5 → 0x2222 in both modes.
- Fill all 64 words with address^0xBEEF, assert clear for one cycle with load=1 on address 3 →
  - busy high for exactly 64 cycles and load/rd_en ignored during it.
  - Afterwards every address reads 0.
- Start a clear, pull rst_n low at sweep word 30 → outputs immediately 0, busy=0. After release, all 64 words read 0 and a write/read to 40 works on the first post-reset cycle.
- Parameter sweep WIDTH=8, ADDR_W=4, BANK_W=2 and WIDTH=32, ADDR_W=8, BANK_W=1 → the write/read and clear scenarios pass, and busy lasts exactly DEPTH cycles.

Source files
------------

// File: rtl/banked_ram.sv
// banked_ram: parametrised banked register RAM with a registered read port,
// selectable read-during-write behaviour and a one-word-per-cycle clear sequencer.
module banked_ram #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BANK_W    = 3,
    parameter int unsigned READ_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              rd_en,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy
);

    localparam int unsigned WORD_W     = ADDR_W - BANK_W;
    localparam int unsigned NBANK      = 1 << BANK_W;
    localparam int unsigned BANK_DEPTH = 1 << WORD_W;
    localparam int unsigned DEPTH      = 1 << ADDR_W;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [WIDTH-1:0]    mem_q [NBANK][BANK_DEPTH];

    logic                wr_en_c;
    logic [ADDR_W-1:0]   wr_addr_c;
    logic [WIDTH-1:0]    wr_data_c;
    logic [BANK_W-1:0]   wr_bank_c;
    logic [WORD_W-1:0]   wr_word_c;
    logic [NBANK-1:0]    bank_sel_c;
    logic [WIDTH-1:0]    rd_data_c;

    // Pre-write word at the requested address (read-first view of the array)
    always_comb begin
        rd_data_c = mem_q[address[ADDR_W-1 -: BANK_W]][address[WORD_W-1:0]];
    end

    // Next-state, write-port steering and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        wr_en_c     = 1'b0;
        wr_addr_c   = address;
        wr_data_c   = in;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    // Starting a sweep drops this edge's load and read
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    wr_en_c = load;
                    if (rd_en) begin
                        out_valid_d = 1'b1;
                        out_d       = (READ_MODE == 1 && load) ? in : rd_data_c;
                    end
                end
            end
            S_CLEAR: begin
                wr_en_c   = 1'b1;
                wr_addr_c = cnt_q;
                wr_data_c = '0;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One-hot bank select for the single write port
    always_comb begin
        wr_bank_c  = wr_addr_c[ADDR_W-1 -: BANK_W];
        wr_word_c  = wr_addr_c[WORD_W-1:0];
        bank_sel_c = wr_en_c ? (NBANK'(1) << wr_bank_c) : '0;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Storage array; each bank only updates when its select bit is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NBANK; b++) begin
                for (int unsigned w = 0; w < BANK_DEPTH; w++) begin
                    mem_q[b][w] <= '0;
                end
            end
        end else begin
            for (int unsigned b = 0; b < NBANK; b++) begin
                if (bank_sel_c[b]) begin
                    mem_q[b][wr_word_c] <= wr_data_c;
                end
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_banked_ram.sv
// tb_banked_ram: four banked_ram configurations driven by shared stimulus and
// checked every cycle against a word-array reference model.
module tb_banked_ram;

    logic        clk;
    logic        rst_n;
    logic        ld;
    logic        rd;
    logic        clr;
    logic [7:0]  addr;
    logic [31:0] din;

    logic [15:0] o0, o1;
    logic [7:0]  o2;
    logic [31:0] o3;
    logic        v0, v1, v2, v3;
    logic        b0, b1, b2, b3;

    // inst 0: defaults read-first; 1: defaults write-first; 2: 8/4/2; 3: 32/8/1 write-first
    banked_ram #(.WIDTH(16), .ADDR_W(6), .BANK_W(3), .READ_MODE(0)) u_rm0 (
        .clk(clk), .rst_n(rst_n), .in(din[15:0]), .load(ld), .address(addr[5:0]),
        .rd_en(rd), .clear(clr), .out(o0), .out_valid(v0), .busy(b0));
    banked_ram #(.WIDTH(16), .ADDR_W(6), .BANK_W(3), .READ_MODE(1)) u_rm1 (
        .clk(clk), .rst_n(rst_n), .in(din[15:0]), .load(ld), .address(addr[5:0]),
        .rd_en(rd), .clear(clr), .out(o1), .out_valid(v1), .busy(b1));
    banked_ram #(.WIDTH(8), .ADDR_W(4), .BANK_W(2), .READ_MODE(0)) u_small (
        .clk(clk), .rst_n(rst_n), .in(din[7:0]), .load(ld), .address(addr[3:0]),
        .rd_en(rd), .clear(clr), .out(o2), .out_valid(v2), .busy(b2));
    banked_ram #(.WIDTH(32), .ADDR_W(8), .BANK_W(1), .READ_MODE(1)) u_wide (
        .clk(clk), .rst_n(rst_n), .in(din), .load(ld), .address(addr),
        .rd_en(rd), .clear(clr), .out(o3), .out_valid(v3), .busy(b3));

    logic [31:0] ao [4];
    logic        av [4];
    logic        ab [4];
    assign ao[0] = 32'(o0);
    assign ao[1] = 32'(o1);
    assign ao[2] = 32'(o2);
    assign ao[3] = o3;
    assign av[0] = v0;
    assign av[1] = v1;
    assign av[2] = v2;
    assign av[3] = v3;
    assign ab[0] = b0;
    assign ab[1] = b1;
    assign ab[2] = b2;
    assign ab[3] = b3;

    // reference model: plain word arrays plus a remaining-sweep-words count
    int unsigned depth_m [4] = '{64, 64, 16, 256};
    logic [31:0] mask_m  [4] = '{32'hFFFF, 32'hFFFF, 32'hFF, 32'hFFFF_FFFF};
    bit          mode_m  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] mm      [4][256];
    int unsigned busy_left [4];
    logic [31:0] eo [4];
    logic        ev [4];

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int a = 0; a < 256; a++) mm[i][a] = '0;
            busy_left[i] = 0;
            eo[i] = '0;
            ev[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int ai;
        logic [31:0] di;
        for (int i = 0; i < 4; i++) begin
            if (busy_left[i] > 0) begin
                mm[i][depth_m[i] - busy_left[i]] = '0;
                busy_left[i]--;
                ev[i] = 1'b0;
            end else if (clr) begin
                busy_left[i] = depth_m[i];
                ev[i] = 1'b0;
            end else begin
                ai = int'(addr) % int'(depth_m[i]);
                di = din & mask_m[i];
                if (rd) begin
                    eo[i] = (mode_m[i] && ld) ? di : mm[i][ai];
                    ev[i] = 1'b1;
                end else begin
                    ev[i] = 1'b0;
                end
                if (ld) mm[i][ai] = di;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("out%0d", i), ao[i], eo[i]);
            check($sformatf("valid%0d", i), 32'(av[i]), 32'(ev[i]));
            check($sformatf("busy%0d", i), 32'(ab[i]), 32'(busy_left[i] > 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input logic l, input logic r, input logic c,
                          input logic [7:0] a, input logic [31:0] d);
        ld = l; rd = r; clr = c; addr = a; din = d;
    endtask

    task automatic read_sweep();
        for (int a = 0; a < 256; a++) begin
            set_in(1'b0, 1'b1, 1'b0, 8'(a), 32'h0);
            step();
        end
        set_in(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    endtask

    int busy_cnt [4];

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // reads of a freshly reset array
        for (int k = 0; k < 3; k++) begin
            logic [7:0] ra [3];
            ra = '{8'd0, 8'd21, 8'd63};
            set_in(1'b0, 1'b1, 1'b0, ra[k], 32'h0);
            step();
            check("rst_rd_out", ao[0], 32'h0);
            check("rst_rd_valid", 32'(av[0]), 32'h1);
        end

        // two writes then back-to-back reads
        set_in(1'b1, 1'b0, 1'b0, 8'd9, 32'hA5A5);  step();
        set_in(1'b1, 1'b0, 1'b0, 8'd57, 32'h1234); step();
        set_in(1'b0, 1'b1, 1'b0, 8'd9, 32'h0);     step();
        check("rd9", ao[0], 32'hA5A5);
        set_in(1'b0, 1'b1, 1'b0, 8'd57, 32'h0);    step();
        check("rd57", ao[0], 32'h1234);
        check("rd57_valid", 32'(av[0]), 32'h1);
        set_in(1'b0, 1'b1, 1'b0, 8'd10, 32'h0);    step();
        check("rd10", ao[0], 32'h0);
        read_sweep();

        // same-edge read and write
        set_in(1'b1, 1'b0, 1'b0, 8'd5, 32'h1111); step();
        set_in(1'b1, 1'b1, 1'b0, 8'd5, 32'h2222); step();
        check("rdw_rm0", ao[0], 32'h1111);
        check("rdw_rm1", ao[1], 32'h2222);
        set_in(1'b0, 1'b1, 1'b0, 8'd5, 32'h0);    step();
        check("rd5_rm0", ao[0], 32'h2222);
        check("rd5_rm1", ao[1], 32'h2222);

        // fill, then clear with a colliding load; ops during the sweep are ignored
        for (int a = 0; a < 256; a++) begin
            set_in(1'b1, 1'b0, 1'b0, 8'(a), 32'(a) ^ 32'hBEEF);
            step();
        end
        foreach (busy_cnt[i]) busy_cnt[i] = 0;
        set_in(1'b1, 1'b0, 1'b1, 8'd3, 32'h5555);
        step();
        foreach (busy_cnt[i]) busy_cnt[i] += int'(ab[i]);
        for (int c = 0; c < 300; c++) begin
            if (c < 14) set_in($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 1'b0,
                               8'($urandom), $urandom);
            else        set_in(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
            step();
            foreach (busy_cnt[i]) busy_cnt[i] += int'(ab[i]);
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("busy_len%0d", i), 32'(busy_cnt[i]), depth_m[i]);
        for (int a = 0; a < 64; a++) begin
            set_in(1'b0, 1'b1, 1'b0, 8'(a), 32'h0);
            step();
            check("post_clear_rd", ao[0], 32'h0);
        end
        read_sweep();

        // reset in the middle of a sweep
        set_in(1'b1, 1'b0, 1'b0, 8'd40, 32'h7777); step();
        set_in(1'b0, 1'b1, 1'b0, 8'd40, 32'h0);    step();
        set_in(1'b0, 1'b0, 1'b1, 8'd0, 32'h0);     step();
        set_in(1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        for (int c = 0; c < 30; c++) step();
        rst_n = 1'b0;
        #1;
        check("abort_out", ao[0], 32'h0);
        check("abort_busy", 32'(ab[0]), 32'h0);
        check("abort_valid", 32'(av[1]), 32'h0);
        check("abort_busy_wide", 32'(ab[3]), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 8'd40, 32'h0BAD); step();
        set_in(1'b0, 1'b1, 1'b0, 8'd40, 32'h0);    step();
        check("post_rst_rd40", ao[0], 32'h0BAD);
        read_sweep();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_in($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                   $urandom_range(0, 49) == 0, 8'($urandom), $urandom);
            step();
        end
        set_in(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        for (int c = 0; c < 260; c++) step();
        read_sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
